// File: rtl/filter2d_pkg.sv
// Shared constants, enums and helpers for the 3x3 convolution engine.
// Phase map: reads at ph 0..8, acc clear at ph 1, write at ph 11.
package filter2d_pkg;

  localparam int PH_LAST      = 11;
  localparam int PH_RD_LAST   = 8;
  localparam int PH_ACC_CLR   = 1;
  localparam int PH_MAC_FIRST = 2;
  localparam int PH_MAC_LAST  = 10;
  localparam int NTAP         = 9;

  typedef enum logic {
    BORDER_ZERO = 1'b0,
    BORDER_REPL = 1'b1
  } border_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic int acc_width(int pix_w, int coef_w);
    return pix_w + coef_w + 4;
  endfunction

  // Binomial blur weights {1,2,1,2,4,2,1,2,1}, before scaling.
  function automatic int default_tap(int k);
    case (k)
      4:         return 4;
      1, 3, 5, 7: return 2;
      default:   return 1;
    endcase
  endfunction

endpackage

// File: rtl/filter2d_mac_rnd.sv
// Multiply-accumulate of unsigned pixel by signed tap, with
// rounding arithmetic right shift and unsigned saturation.
module filter2d_mac_rnd
  import filter2d_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = acc_width(PIX_W, COEF_W)
)(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic [PIX_W-1:0]         pd,
  input  logic signed [COEF_W-1:0] coef,
  input  logic [3:0]               shift,
  output logic [PIX_W-1:0]         res
);

  localparam int PW = PIX_W + COEF_W + 1;
  localparam logic signed [ACC_W:0] MAXV =
    {{(ACC_W+1-PIX_W){1'b0}}, {PIX_W{1'b1}}};

  logic signed [ACC_W-1:0] acc;
  logic signed [PIX_W:0]   pds;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W:0]   accx;
  logic signed [ACC_W:0]   half;
  logic signed [ACC_W:0]   sum;
  logic signed [ACC_W:0]   rnd;

  assign pds  = {1'b0, pd};
  assign prod = PW'(pds) * PW'(coef);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + {{(ACC_W-PW){prod[PW-1]}}, prod};
    end
  end

  always_comb begin
    res  = '0;
    half = '0;
    accx = {acc[ACC_W-1], acc};
    if (shift != 4'd0)
      half = (ACC_W+1)'(1) << (shift - 4'd1);
    sum = accx + half;
    rnd = sum >>> shift;
    if (rnd < 0)
      res = '0;
    else if (rnd > MAXV)
      res = '1;
    else
      res = rnd[PIX_W-1:0];
  end

endmodule

// File: rtl/filter2d_gen.sv
// Parametrised 3x3 convolution over an SRAM-resident frame, with
// zero/replicate borders, runtime shift and abort.
module filter2d_gen
  import filter2d_pkg::*;
#(
  parameter int IMG_W   = 256,
  parameter int IMG_H   = 256,
  parameter int PIX_W   = 8,
  parameter int COEF_W  = 8,
  parameter int ADDR_W  = 17,
  parameter int WR_BASE = IMG_W * IMG_H
)(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              border_mode,
  input  logic [3:0]        out_shift,
  output logic              busy,
  output logic              finish,
  output logic              cs,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [PIX_W-1:0]  din,
  input  logic [PIX_W-1:0]  dout,
  input  logic              h_write,
  input  logic [3:0]        h_idx,
  input  logic [COEF_W-1:0] h_data
);

  localparam int ACC_W = acc_width(PIX_W, COEF_W);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int CW = ((XW > YW) ? XW : YW) + 2;

  localparam logic [3:0] P_LAST = 4'(PH_LAST);
  localparam logic [3:0] P_RDL  = 4'(PH_RD_LAST);
  localparam logic [3:0] P_CLR  = 4'(PH_ACC_CLR);
  localparam logic [3:0] P_MAC0 = 4'(PH_MAC_FIRST);
  localparam logic [3:0] P_MAC1 = 4'(PH_MAC_LAST);

  localparam logic [XW-1:0] X_END = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_END = YW'(IMG_H - 1);
  localparam logic signed [CW-1:0] XMAX = CW'(IMG_W - 1);
  localparam logic signed [CW-1:0] YMAX = CW'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(WR_BASE);

  state_e state, state_nx;
  border_e bmode;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [3:0]    ph;
  logic [3:0]    shift;

  logic signed [COEF_W-1:0] h [NTAP];

  logic [1:0] col, row;
  logic signed [CW-1:0] tx, ty, cx, cy;
  logic in_rng;
  logic run, last_px;
  logic rd_go, wr_go;
  logic rd_v, pd_v;
  logic [PIX_W-1:0] pd;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic mac_en, acc_clr;
  logic [3:0] tap_sel;
  logic [PIX_W-1:0] res;

  assign run     = (state == ST_RUN);
  assign busy    = run;
  assign last_px = (x == X_END) && (y == Y_END);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NTAP; k++)
        h[k] <= COEF_W'(default_tap(k) << (COEF_W - 5));
    end else if (h_write && !run && h_idx < 4'(NTAP)) begin
      h[h_idx] <= h_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bmode <= BORDER_ZERO;
      shift <= 4'(COEF_W - 1);
    end else if (!run && start && !abort) begin
      bmode <= border_e'(border_mode);
      shift <= out_shift;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (start && !abort) state_nx = ST_RUN;
      ST_RUN: begin
        if (abort)
          state_nx = ST_IDLE;
        else if (ph == P_LAST && last_px)
          state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x  <= '0;
      y  <= '0;
      ph <= '0;
    end else if (abort || !run) begin
      x  <= '0;
      y  <= '0;
      ph <= '0;
    end else if (ph == P_LAST) begin
      ph <= '0;
      if (x == X_END) begin
        x <= '0;
        y <= (y == Y_END) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end else begin
      ph <= ph + 4'd1;
    end
  end

  // Tap geometry for the read issued in this phase.
  always_comb begin
    row = 2'(ph / 4'd3);
    col = 2'(ph % 4'd3);
    tx  = CW'(x) + CW'(col) - CW'(1);
    ty  = CW'(y) + CW'(row) - CW'(1);
    in_rng = (tx >= 0) && (tx <= XMAX) && (ty >= 0) && (ty <= YMAX);
    cx = (tx < 0) ? '0 : (tx > XMAX) ? XMAX : tx;
    cy = (ty < 0) ? '0 : (ty > YMAX) ? YMAX : ty;
  end

  assign rd_addr = ADDR_W'(cy) * ADDR_W'(IMG_W) + ADDR_W'(cx);
  assign wr_addr = BASE + ADDR_W'(y) * ADDR_W'(IMG_W) + ADDR_W'(x);

  assign rd_go = run && !abort && (ph <= P_RDL) &&
                 (in_rng || bmode == BORDER_REPL);
  assign wr_go = run && !abort && (ph == P_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_v <= 1'b0;
      pd_v <= 1'b0;
      pd   <= '0;
    end else if (abort) begin
      rd_v <= 1'b0;
      pd_v <= 1'b0;
      pd   <= '0;
    end else begin
      rd_v <= rd_go;
      pd_v <= rd_v;
      if (rd_v) pd <= dout;
    end
  end

  // Skipped zero-border taps arrive with pd_v low and add nothing.
  assign mac_en  = run && !abort && pd_v &&
                   (ph >= P_MAC0) && (ph <= P_MAC1);
  assign acc_clr = abort || (run && ph == P_CLR);
  assign tap_sel = ((ph >= P_MAC0) && (ph <= P_MAC1)) ? ph - P_MAC0 : 4'd0;

  filter2d_mac_rnd #(
    .PIX_W  (PIX_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (acc_clr),
    .en      (mac_en),
    .pd      (pd),
    .coef    (h[tap_sel]),
    .shift   (shift),
    .res     (res)
  );

  always_comb begin
    cs   = rd_go || wr_go;
    we   = wr_go;
    addr = '0;
    din  = '0;
    if (wr_go) begin
      addr = wr_addr;
      din  = res;
    end else if (rd_go) begin
      addr = rd_addr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      finish <= 1'b0;
    else
      finish <= run && !abort && (ph == P_LAST) && last_px;
  end

endmodule

// File: tb/tb_filter2d_gen.sv
// Self-checking bench for filter2d_gen: SRAM model, reference
// convolution feeding a write scoreboard, table plus corner sequences.
module tb_filter2d_gen;

  localparam int W    = 6;
  localparam int H    = 4;
  localparam int PW   = 8;
  localparam int CWD  = 8;
  localparam int AW   = 7;
  localparam int NPIX = W * H;
  localparam int BASE = NPIX;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic border_mode = 1'b0;
  logic [3:0] out_shift = 4'd0;
  logic busy, finish, cs, we;
  logic [AW-1:0] addr;
  logic [PW-1:0] din;
  logic [PW-1:0] dout = '0;
  logic h_write = 1'b0;
  logic [3:0] h_idx = 4'd0;
  logic [CWD-1:0] h_data = '0;

  always #5 clk = ~clk;

  filter2d_gen #(
    .IMG_W(W), .IMG_H(H), .PIX_W(PW), .COEF_W(CWD),
    .ADDR_W(AW), .WR_BASE(BASE)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .border_mode(border_mode), .out_shift(out_shift),
    .busy(busy), .finish(finish), .cs(cs), .we(we),
    .addr(addr), .din(din), .dout(dout),
    .h_write(h_write), .h_idx(h_idx), .h_data(h_data)
  );

  typedef struct {
    int addr;
    int data;
    int nrd;
  } exp_t;

  typedef struct {
    int h[9];
    bit set_h;
    bit bm;
    int sh;
    int pat;
    int cval;
    int e00;
    int e20;
    int e21;
  } test_t;

  exp_t sbq[$];
  exp_t ex;
  int checks = 0;
  int errors = 0;
  int img [1<<AW];
  int out_mem [1<<AW];
  int th [9];
  int busy_cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int fin_cnt = 0;

  always @(posedge clk)
    if (cs && !we) dout <= PW'(img[addr]);

  always @(negedge clk) begin
    if (busy) busy_cyc++;
    if (finish) fin_cnt++;
    if (cs && !we) rd_cnt++;
    if (cs && we) begin
      wr_cnt++;
      checks++;
      out_mem[addr] = int'(din);
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d din=%0d", addr, din);
      end else begin
        ex = sbq.pop_front();
        if (int'(addr) != ex.addr || int'(din) != ex.data || rd_cnt != ex.nrd) begin
          errors++;
          $display("FAIL pixel_write actual addr=%0d din=%0d reads=%0d required addr=%0d din=%0d reads=%0d",
                   addr, din, rd_cnt, ex.addr, ex.data, ex.nrd);
        end
      end
      rd_cnt = 0;
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic void model_frame(input bit bm, input int sh);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        int acc = 0;
        int nrd = 0;
        int r;
        for (int k = 0; k < 9; k++) begin
          int tx = x + k % 3 - 1;
          int ty = y + k / 3 - 1;
          bit inr = (tx >= 0 && tx < W && ty >= 0 && ty < H);
          if (inr || bm) begin
            int cx = (tx < 0) ? 0 : (tx >= W) ? W - 1 : tx;
            int cy = (ty < 0) ? 0 : (ty >= H) ? H - 1 : ty;
            acc += img[cy * W + cx] * th[k];
            nrd++;
          end
        end
        r = (sh > 0) ? ((acc + (1 << (sh - 1))) >>> sh) : acc;
        if (r < 0) r = 0;
        if (r > 255) r = 255;
        sbq.push_back('{BASE + y * W + x, r, nrd});
      end
    end
  endfunction

  task automatic fill_img(input int pat, input int cval);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        case (pat)
          0:       img[y * W + x] = (x + y) % 256;
          1:       img[y * W + x] = cval;
          default: img[y * W + x] = int'($urandom_range(0, 255));
        endcase
  endtask

  task automatic set_taps(input int hv[9]);
    for (int k = 0; k < 9; k++) begin
      @(posedge clk);
      #1;
      h_write = 1'b1;
      h_idx   = 4'(k);
      h_data  = CWD'(hv[k]);
      th[k]   = hv[k];
    end
    @(posedge clk);
    #1 h_write = 1'b0;
  endtask

  task automatic start_frame(input bit bm, input int sh,
                             input bit hw, input int hi, input int hd);
    if (hw) begin
      h_write = 1'b1;
      h_idx   = 4'(hi);
      h_data  = CWD'(hd);
      th[hi]  = hd;
    end
    for (int i = 0; i < NPIX; i++) out_mem[BASE + i] = -1;
    model_frame(bm, sh);
    border_mode = bm;
    out_shift   = 4'(sh);
    start       = 1'b1;
    rd_cnt      = 0;
    wr_cnt      = 0;
    @(posedge clk);
    #1;
    start    = 1'b0;
    h_write  = 1'b0;
    busy_cyc = 0;
    chk("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_done(input bit b2b);
    bit seen = 1'b0;
    for (int i = 0; i < 12 * NPIX + 40 && !seen; i++) begin
      @(negedge clk);
      if (finish) seen = 1'b1;
    end
    chk("finish_seen", int'(seen), 1);
    chk("frame_cycles", busy_cyc, 12 * NPIX);
    chk("scoreboard_drained", sbq.size(), 0);
    sbq.delete();
    if (!b2b) begin
      @(negedge clk);
      chk("finish_pulse_len", int'(finish), 0);
      chk("idle_after_frame", int'(busy), 0);
    end
  endtask

  test_t tv [8];
  int idk [9];
  int mixk [9];
  int fc;

  initial begin
    idk  = '{0, 0, 0, 0, 64, 0, 0, 0, 0};
    mixk = '{-3, 5, -7, 11, 40, -13, 2, -1, 6};
    for (int k = 0; k < 9; k++) th[k] = (k == 4) ? 32 : (k % 2 == 1) ? 16 : 8;

    tv[0] = '{'{0,0,0,0,0,0,0,0,0}, 1'b0, 1'b1, 7, 1, 100, 100, 100, 100};
    tv[1] = '{'{0,0,0,0,0,0,0,0,0}, 1'b0, 1'b0, 7, 1, 100, 56, 75, 100};
    tv[2] = '{'{0,0,0,0,64,0,0,0,0}, 1'b1, 1'b0, 6, 0, 0, 0, 2, 3};
    tv[3] = '{'{0,0,0,0,64,0,0,0,0}, 1'b1, 1'b1, 6, 0, 0, 0, 2, 3};
    tv[4] = '{'{0,0,0,0,-128,0,0,0,0}, 1'b1, 1'b1, 7, 1, 50, 0, 0, 0};
    tv[5] = '{'{0,0,0,0,127,0,0,0,0}, 1'b1, 1'b0, 0, 1, 255, 255, 255, 255};
    tv[6] = '{'{-3,5,-7,11,40,-13,2,-1,6}, 1'b1, 1'b0, 5, 2, 0, -1, -1, -1};
    tv[7] = '{'{-3,5,-7,11,40,-13,2,-1,6}, 1'b1, 1'b1, 5, 2, 0, -1, -1, -1};

    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_finish", int'(finish), 0);
    chk("rst_cs_we", int'({cs, we}), 0);
    chk("rst_addr_din", int'(addr) + int'(din), 0);
    #11 reset_n = 1'b1;
    @(negedge clk);
    chk("idle_cs", int'(cs), 0);

    for (int i = 0; i < 8; i++) begin
      if (tv[i].set_h) set_taps(tv[i].h);
      fill_img(tv[i].pat, tv[i].cval);
      @(posedge clk);
      #1;
      start_frame(tv[i].bm, tv[i].sh, 1'b0, 0, 0);
      wait_done(1'b0);
      if (tv[i].e00 >= 0) begin
        chk($sformatf("t%0d_px00", i), out_mem[BASE], tv[i].e00);
        chk($sformatf("t%0d_px20", i), out_mem[BASE + 2], tv[i].e20);
        chk($sformatf("t%0d_px21", i), out_mem[BASE + W + 2], tv[i].e21);
      end
    end

    // Abort at pixel (3,1) phase 5, then a clean restart.
    fill_img(2, 0);
    @(posedge clk);
    #1;
    start_frame(1'b0, 5, 1'b0, 0, 0);
    repeat (12 * (W + 3) + 5) @(posedge clk);
    #1 abort = 1'b1;
    fc = fin_cnt;
    @(negedge clk);
    chk("abort_no_access", int'(cs), 0);
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_writes", wr_cnt, W + 3);
    repeat (30) @(negedge clk);
    chk("abort_no_finish", fin_cnt, fc);
    chk("abort_stays_idle", int'(busy), 0);
    sbq.delete();
    start_frame(1'b0, 5, 1'b0, 0, 0);
    wait_done(1'b0);

    // Mid-frame start and tap write are dropped.
    start_frame(1'b1, 5, 1'b0, 0, 0);
    repeat (150) @(posedge clk);
    #1;
    start   = 1'b1;
    h_write = 1'b1;
    h_idx   = 4'd4;
    h_data  = '0;
    @(posedge clk);
    #1;
    start   = 1'b0;
    h_write = 1'b0;
    wait_done(1'b0);

    // Tap write in the start cycle is used; next frame back-to-back.
    set_taps('{0, 0, 0, 0, 0, 0, 0, 0, 0});
    fill_img(0, 0);
    @(posedge clk);
    #1;
    start_frame(1'b0, 6, 1'b1, 4, 64);
    wait_done(1'b1);
    fill_img(2, 0);
    start_frame(1'b1, 6, 1'b0, 0, 0);
    wait_done(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
